// File: rtl/adsr_enveloper_multi.sv
// Multi-channel gate-driven ADSR envelope generator with run-time rates and legato retrigger.
// Define ADSR_EXP_RELEASE_EN for an exponential release tail with a linear floor.
module adsr_enveloper_multi #(
  parameter int NUM_CH      = 4,
  parameter int VOLUME_BITS = 8,
  parameter int FRAC_BITS   = 8,
  parameter int RATE_BITS   = 16,
  parameter int TICK_DIV    = 256
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             gate,
  input  logic [RATE_BITS-1:0]          attack_rate,
  input  logic [RATE_BITS-1:0]          decay_rate,
  input  logic [VOLUME_BITS-1:0]        sustain_level,
  input  logic [RATE_BITS-1:0]          release_rate,
  output logic [NUM_CH*VOLUME_BITS-1:0] volume_out,
  output logic [NUM_CH-1:0]             active
);

  localparam int ACC_BITS = VOLUME_BITS + FRAC_BITS;
  localparam int EXT_BITS = ACC_BITS + 1;
  localparam int CNT_BITS = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [EXT_BITS-1:0] MAXA = {1'b0, {ACC_BITS{1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } state_t;

  logic [CNT_BITS-1:0] r_presc;
  logic                w_tick;
  logic [NUM_CH-1:0]   r_gate_prev;
  logic [EXT_BITS-1:0] w_att_rate;
  logic [EXT_BITS-1:0] w_dec_rate;
  logic [EXT_BITS-1:0] w_rel_rate;
  logic [EXT_BITS-1:0] w_susa;

  assign w_tick = (r_presc == CNT_BITS'(TICK_DIV - 1));

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_gate_prev <= '0;
    end else begin
      r_gate_prev <= gate;
    end
  end

  // One extra headroom bit so sums carry and differences borrow instead of wrapping.
  assign w_att_rate = EXT_BITS'(attack_rate);
  assign w_dec_rate = EXT_BITS'(decay_rate);
  assign w_rel_rate = EXT_BITS'(release_rate);
  assign w_susa     = {1'b0, sustain_level, {FRAC_BITS{1'b0}}};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t              r_state;
      state_t              w_state_next;
      logic [ACC_BITS-1:0] r_acc;
      logic [ACC_BITS-1:0] w_acc_next;
      logic                w_rise;
      logic                w_fall;
      logic                w_fall_live;
      logic [EXT_BITS-1:0] w_acc_ext;
      logic [EXT_BITS-1:0] w_att_sum;
      logic [EXT_BITS-1:0] w_dec_diff;
      logic [EXT_BITS-1:0] w_rel_step;
      logic [EXT_BITS-1:0] w_rel_diff;

      assign w_rise      = gate[gi] & ~r_gate_prev[gi];
      assign w_fall      = ~gate[gi] & r_gate_prev[gi];
      assign w_fall_live = w_fall & ((r_state == ST_ATTACK) ||
                                     (r_state == ST_DECAY) ||
                                     (r_state == ST_SUSTAIN));

      assign w_acc_ext  = {1'b0, r_acc};
      assign w_att_sum  = w_acc_ext + w_att_rate;
      assign w_dec_diff = w_acc_ext - w_dec_rate;

`ifdef ADSR_EXP_RELEASE_EN
      logic [EXT_BITS-1:0] w_acc_shr;
      assign w_acc_shr  = w_acc_ext >> 4;
      assign w_rel_step = (w_acc_shr > w_rel_rate) ? w_acc_shr : w_rel_rate;
`else
      assign w_rel_step = w_rel_rate;
`endif

      assign w_rel_diff = w_acc_ext - w_rel_step;

      always_ff @(posedge mclk) begin
        if (rst) begin
          r_state <= ST_IDLE;
          r_acc   <= '0;
        end else begin
          r_state <= w_state_next;
          r_acc   <= w_acc_next;
        end
      end

      // Edges only change state; the level keeps its value so retriggers do not click.
      always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        if (w_rise) begin
          w_state_next = ST_ATTACK;
        end else if (w_fall_live) begin
          w_state_next = ST_RELEASE;
        end else if (w_tick) begin
          case (r_state)
            ST_ATTACK: begin
              if ((attack_rate == '0) || (w_att_sum >= MAXA)) begin
                w_acc_next   = MAXA[ACC_BITS-1:0];
                w_state_next = ST_DECAY;
              end else begin
                w_acc_next = w_att_sum[ACC_BITS-1:0];
              end
            end
            ST_DECAY: begin
              if ((decay_rate == '0) || w_dec_diff[EXT_BITS-1] || (w_dec_diff <= w_susa)) begin
                w_acc_next   = w_susa[ACC_BITS-1:0];
                w_state_next = ST_SUSTAIN;
              end else begin
                w_acc_next = w_dec_diff[ACC_BITS-1:0];
              end
            end
            ST_SUSTAIN: begin
              w_acc_next = w_susa[ACC_BITS-1:0];
            end
            ST_RELEASE: begin
              if ((release_rate == '0) || w_rel_diff[EXT_BITS-1] || (w_rel_diff == '0)) begin
                w_acc_next   = '0;
                w_state_next = ST_IDLE;
              end else begin
                w_acc_next = w_rel_diff[ACC_BITS-1:0];
              end
            end
            default: begin
              w_acc_next = '0;
            end
          endcase
        end
      end

      assign volume_out[gi*VOLUME_BITS +: VOLUME_BITS] = r_acc[ACC_BITS-1:FRAC_BITS];
      assign active[gi] = (r_state != ST_IDLE);
    end
  endgenerate

endmodule

// File: tb/tb_adsr_enveloper_multi.sv
// Self-checking bench for adsr_enveloper_multi: directed ADSR scenarios plus randomized gates/rates
// checked every cycle against an integer-arithmetic envelope model.
module tb_adsr_enveloper_multi;
  localparam int NUM_CH      = 4;
  localparam int VOLUME_BITS = 8;
  localparam int FRAC_BITS   = 8;
  localparam int RATE_BITS   = 16;
  localparam int TICK_DIV    = 4;
  localparam int MAXA        = 65535;
  localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  gate = 4'h0;
  logic [15:0] attack_rate = 16'h0;
  logic [15:0] decay_rate = 16'h0;
  logic [7:0]  sustain_level = 8'h0;
  logic [15:0] release_rate = 16'h0;
  logic [31:0] volume_out;
  logic [3:0]  active;

  int n_checks = 0;
  int n_fail = 0;

  int m_cnt;
  int m_state [NUM_CH];
  int m_acc [NUM_CH];
  bit m_gprev [NUM_CH];

  always #5 mclk = ~mclk;

  adsr_enveloper_multi #(
    .NUM_CH(NUM_CH), .VOLUME_BITS(VOLUME_BITS), .FRAC_BITS(FRAC_BITS),
    .RATE_BITS(RATE_BITS), .TICK_DIV(TICK_DIV)
  ) dut (
    .mclk(mclk), .rst(rst), .gate(gate), .attack_rate(attack_rate),
    .decay_rate(decay_rate), .sustain_level(sustain_level),
    .release_rate(release_rate), .volume_out(volume_out), .active(active)
  );

  // Reference envelope: plain integer arithmetic with min/max clamping.
  always @(posedge mclk) begin : model
    bit tick;
    int ns, na, sus, step;
    if (rst) begin
      m_cnt <= 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_state[c] <= M_IDLE;
        m_acc[c]   <= 0;
        m_gprev[c] <= 1'b0;
      end
    end else begin
      tick = (m_cnt == TICK_DIV - 1);
      m_cnt <= tick ? 0 : m_cnt + 1;
      sus = int'(sustain_level) * (1 << FRAC_BITS);
      for (int c = 0; c < NUM_CH; c++) begin
        ns = m_state[c];
        na = m_acc[c];
        if (gate[c] && !m_gprev[c]) begin
          ns = M_ATT;
        end else if (!gate[c] && m_gprev[c] && (ns == M_ATT || ns == M_DEC || ns == M_SUS)) begin
          ns = M_REL;
        end else if (tick) begin
          case (m_state[c])
            M_ATT: begin
              na = (attack_rate == 0) ? MAXA : na + int'(attack_rate);
              if (na >= MAXA) begin na = MAXA; ns = M_DEC; end
            end
            M_DEC: begin
              na = (decay_rate == 0) ? sus : na - int'(decay_rate);
              if (na <= sus) begin na = sus; ns = M_SUS; end
            end
            M_SUS: na = sus;
            M_REL: begin
              step = int'(release_rate);
`ifdef ADSR_EXP_RELEASE_EN
              if ((na / 16) > step) step = na / 16;
`endif
              na = (release_rate == 0) ? 0 : na - step;
              if (na <= 0) begin na = 0; ns = M_IDLE; end
            end
            default: na = 0;
          endcase
        end
        m_state[c] <= ns;
        m_acc[c]   <= na;
        m_gprev[c] <= gate[c];
      end
    end
  end

  function automatic logic [31:0] exp_volume();
    logic [31:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c*8 +: 8] = 8'(m_acc[c] >> FRAC_BITS);
    return v;
  endfunction

  function automatic logic [3:0] exp_active();
    logic [3:0] a;
    for (int c = 0; c < NUM_CH; c++) a[c] = (m_state[c] != M_IDLE);
    return a;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    gate = 4'hF;
    repeat (3) @(negedge mclk);
    n_checks++;
    if (volume_out !== 32'h0 || active !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vol=%h act=%b want vol=0 act=0", volume_out, active);
    end
    rst = 1'b0;
    @(negedge mclk);
    n_checks++;
    if (active !== 4'hF) begin
      n_fail++;
      $display("FAIL first_rise_after_reset: got act=%b want 1111", active);
    end
    gate = 4'h0;
    rst = 1'b1;
    repeat (2) @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
    n_checks++;
    if (volume_out !== exp_volume() || active !== exp_active() || active !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_idle: got vol=%h act=%b want vol=%h act=%b", volume_out, active, exp_volume(), exp_active());
    end
  endtask

  task automatic test_adsr();
    int cyc = 0, hit255 = -1, hit128 = -1, prev;
    bit bad_step = 0;
    attack_rate = 16'h1000; decay_rate = 16'h0100; sustain_level = 8'h80; release_rate = 16'h0800;
    gate = 4'b0001;
    for (int i = 0; i < 800 && hit128 < 0; i++) begin
      prev = volume_out[7:0];
      @(negedge mclk);
      cyc++;
      n_checks++;
      if (volume_out !== exp_volume() || active !== exp_active()) begin
        n_fail++;
        $display("FAIL adsr_track t=%0t: got vol=%h act=%b want vol=%h act=%b", $time, volume_out, active, exp_volume(), exp_active());
      end
      if (hit255 < 0 && volume_out[7:0] == 8'd255) hit255 = cyc;
      else if (hit255 >= 0 && volume_out[7:0] != prev[7:0] && int'(volume_out[7:0]) != prev - 1) bad_step = 1;
      if (hit255 >= 0 && volume_out[7:0] == 8'd128) hit128 = cyc;
    end
    n_checks++;
    if (hit255 < 61 || hit255 > 66) begin
      n_fail++;
      $display("FAIL attack_time: got %0d cycles to 255 want 61..66", hit255);
    end
    n_checks++;
    if (hit128 - hit255 != 508 || bad_step) begin
      n_fail++;
      $display("FAIL decay_time: got %0d cycles 255->128 (bad_step=%0d) want 508 steps of 1", hit128 - hit255, bad_step);
    end
    repeat (80) begin
      @(negedge mclk);
      n_checks++;
      if (volume_out !== exp_volume() || active !== exp_active()) begin
        n_fail++;
        $display("FAIL sustain_track t=%0t: got vol=%h act=%b want vol=%h act=%b", $time, volume_out, active, exp_volume(), exp_active());
      end
    end
    n_checks++;
    if (volume_out !== 32'h0000_0080 || active !== 4'b0001) begin
      n_fail++;
      $display("FAIL sustain_hold: got vol=%h act=%b want vol=00000080 act=0001", volume_out, active);
    end
  endtask

  task automatic test_release();
    int cyc = 0, prev = 0;
    release_rate = 16'h0800;
    gate = 4'b0000;
    for (int i = 0; i < 100 && active[0]; i++) begin
      prev = volume_out[7:0];
      @(negedge mclk);
      cyc++;
      n_checks++;
      if (volume_out !== exp_volume() || active !== exp_active()) begin
        n_fail++;
        $display("FAIL release_track t=%0t: got vol=%h act=%b want vol=%h act=%b", $time, volume_out, active, exp_volume(), exp_active());
      end
    end
    n_checks++;
    if (active[0] !== 1'b0 || volume_out[7:0] !== 8'd0 || prev != 8 || cyc < 62 || cyc > 65) begin
      n_fail++;
      $display("FAIL release_end: got act0=%b vol0=%0d prev=%0d cycles=%0d want act0=0 vol0=0 prev=8 cycles 62..65",
               active[0], volume_out[7:0], prev, cyc);
    end
  endtask

  task automatic test_retrigger();
    int first = -1, changes = 0, minv = 255, prev;
    attack_rate = 16'h0; decay_rate = 16'h0; sustain_level = 8'h80;
    gate = 4'b0001;
    repeat (16) @(negedge mclk);
    n_checks++;
    if (volume_out[7:0] !== 8'd128) begin
      n_fail++;
      $display("FAIL retrig_setup: got vol0=%0d want 128", volume_out[7:0]);
    end
    release_rate = 16'h0800;
    gate = 4'b0000;
    for (int i = 0; i < 60 && volume_out[7:0] != 8'd64; i++) @(negedge mclk);
    n_checks++;
    if (volume_out[7:0] !== 8'd64 || volume_out !== exp_volume()) begin
      n_fail++;
      $display("FAIL retrig_release_64: got vol=%h want vol0=64 model=%h", volume_out, exp_volume());
    end
    attack_rate = 16'h1000;
    gate = 4'b0001;
    for (int i = 0; i < 80 && volume_out[7:0] != 8'd255; i++) begin
      prev = volume_out[7:0];
      @(negedge mclk);
      n_checks++;
      if (volume_out !== exp_volume() || active !== exp_active()) begin
        n_fail++;
        $display("FAIL retrig_track t=%0t: got vol=%h act=%b want vol=%h act=%b", $time, volume_out, active, exp_volume(), exp_active());
      end
      if (int'(volume_out[7:0]) < minv) minv = volume_out[7:0];
      if (volume_out[7:0] != prev[7:0]) begin
        changes++;
        if (first < 0) first = volume_out[7:0];
      end
    end
    n_checks++;
    if (first != 80 || changes != 12 || minv < 64) begin
      n_fail++;
      $display("FAIL retrig_attack: got first=%0d steps=%0d min=%0d want first=80 steps=12 min>=64", first, changes, minv);
    end
  endtask

  task automatic test_edge_tick();
    int v, nxt = -1;
    release_rate = 16'h0;
    gate = 4'b0000;
    repeat (8) @(negedge mclk);
    attack_rate = 16'h0100;
    gate = 4'b0001;
    for (int i = 0; i < 460 && volume_out[7:0] != 8'd100; i++) @(negedge mclk);
    n_checks++;
    if (volume_out !== exp_volume() || volume_out[7:0] !== 8'd100) begin
      n_fail++;
      $display("FAIL attack_to_100: got vol=%h want vol0=100 model=%h", volume_out, exp_volume());
    end
    release_rate = 16'h0100;
    gate = 4'b0000;
    for (int i = 0; i < 8 && nxt < 0; i++) begin
      @(negedge mclk);
      if (volume_out[7:0] != 8'd100) nxt = volume_out[7:0];
    end
    n_checks++;
    if (nxt != 99 || active[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_in_attack: got next=%0d act0=%b want next=99 act0=1", nxt, active[0]);
    end
    for (int i = 0; i < 8 && m_cnt != TICK_DIV - 1; i++) @(negedge mclk);
    v = volume_out[7:0];
    gate = 4'b0001;
    @(negedge mclk);
    n_checks++;
    if (volume_out[7:0] !== 8'(v) || volume_out !== exp_volume() || active[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_on_tick: got vol0=%0d act0=%b want vol0=%0d act0=1", volume_out[7:0], active[0], v);
    end
    repeat (TICK_DIV) @(negedge mclk);
    n_checks++;
    if (volume_out[7:0] !== 8'(v + 1)) begin
      n_fail++;
      $display("FAIL attack_after_rise: got vol0=%0d want %0d", volume_out[7:0], v + 1);
    end
  endtask

  task automatic test_zero_rates();
    int vals [3];
    int n = 0, prev;
    bit act_at_zero = 1'b1;
    release_rate = 16'h0;
    gate = 4'b0000;
    repeat (8) @(negedge mclk);
    attack_rate = 16'h0; decay_rate = 16'h0; sustain_level = 8'h80;
    gate = 4'b0001;
    for (int i = 0; i < 40 && n < 3; i++) begin
      prev = volume_out[7:0];
      @(negedge mclk);
      n_checks++;
      if (volume_out !== exp_volume() || active !== exp_active()) begin
        n_fail++;
        $display("FAIL zero_rate_track t=%0t: got vol=%h act=%b want vol=%h act=%b", $time, volume_out, active, exp_volume(), exp_active());
      end
      if (volume_out[7:0] != prev[7:0]) begin
        vals[n] = volume_out[7:0];
        if (n == 2) act_at_zero = active[0];
        n++;
        if (n == 2) gate = 4'b0000;
      end
    end
    n_checks++;
    if (n != 3 || vals[0] != 255 || vals[1] != 128 || vals[2] != 0 || act_at_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_rates: got n=%0d seq=%0d,%0d,%0d act_at_0=%b want 255,128,0 act=0",
               n, vals[0], vals[1], vals[2], act_at_zero);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) gate[$urandom_range(3)] ^= 1'b1;
      if ($urandom_range(63) == 0) begin
        case ($urandom_range(3))
          0: attack_rate = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom_range(16'h2000, 1));
          1: decay_rate = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom_range(16'h0800, 1));
          2: release_rate = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom_range(16'hFFFF, 1));
          default: sustain_level = ($urandom_range(3) == 0) ? 8'h0 : 8'($urandom);
        endcase
      end
      rst = (i >= 2000 && i < 2002);
      @(negedge mclk);
      n_checks++;
      if (volume_out !== exp_volume() || active !== exp_active()) begin
        n_fail++;
        $display("FAIL random_track i=%0d: got vol=%h act=%b want vol=%h act=%b", i, volume_out, active, exp_volume(), exp_active());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_adsr();
    test_release();
    test_retrigger();
    test_edge_tick();
    test_zero_rates();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
